// File: rtl/next_pc_gen_pkg.sv
// next_pc_gen_pkg
// Shared definitions for the next-PC generator:
//   WORD_SIZE            - machine word / PC width
//   CTR_SNT..CTR_ST      - 2-bit direction counter encodings
//                          (strongly/weakly not-taken, weakly/strongly taken)
package next_pc_gen_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/sat_counter_2b.sv
// sat_counter_2b
// Combinational 2-bit saturating direction counter step.
// Ports:
//   cur_ctr  in  [1:0]  current counter value
//   taken    in         resolved direction (1 = count up, 0 = count down)
//   next_ctr out [1:0]  updated value, clamped at CTR_SNT / CTR_ST
module sat_counter_2b
  import next_pc_gen_pkg::*;
(
  input  logic [1:0] cur_ctr,
  input  logic       taken,
  output logic [1:0] next_ctr
);

  always_comb begin
    next_ctr = cur_ctr;
    if (taken) begin
      if (cur_ctr != CTR_ST) next_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != CTR_SNT) next_ctr = cur_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/next_pc_gen.sv
// next_pc_gen
// IF-stage next-PC generator. Holds a direct-mapped BTB with 2-bit direction
// counters and chooses between the sequential PC, a predicted-taken target and
// an EX-stage redirect. The only state is the BTB; the PC itself lives in the
// PC register that consumes PC_next / PC_update.
// Optional build macro: BTB_STATS_EN adds stat_branches / stat_mispredicts.
// Ports:
//   clk, reset_n       clock (rising edge), synchronous active-low reset
//   PC_cur             current PC (combinational BTB lookup key)
//   stall              IF stall, suppresses PC_update unless mispredict
//   resolve_*          EX resolution of a control instruction (BTB training)
//   mispredict         redirect request, correct_pc is the new PC
//   PC_next            next PC value
//   PC_update          PC register load enable
//   pred_taken         prediction made for PC_cur
//   stat_branches      (BTB_STATS_EN) saturating count of resolve_valid cycles
//   stat_mispredicts   (BTB_STATS_EN) saturating count of mispredict cycles
module next_pc_gen
  import next_pc_gen_pkg::*;
#(
  parameter int BTB_INDEX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] PC_cur,
  input  logic                 stall,
  input  logic                 resolve_valid,
  input  logic [WORD_SIZE-1:0] resolve_pc,
  input  logic                 resolve_taken,
  input  logic [WORD_SIZE-1:0] resolve_target,
  input  logic                 mispredict,
  input  logic [WORD_SIZE-1:0] correct_pc,
  output logic [WORD_SIZE-1:0] PC_next,
  output logic                 PC_update,
  output logic                 pred_taken
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
`endif
);

  localparam int ENTRIES  = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - BTB_INDEX_BITS;

  // Read views of the per-entry storage.
  logic                 valid_arr [ENTRIES];
  logic [TAG_BITS-1:0]  tag_arr   [ENTRIES];
  logic [WORD_SIZE-1:0] tgt_arr   [ENTRIES];
  logic [1:0]           ctr_arr   [ENTRIES];

  // ---------------- Lookup (pre-edge contents, no write-through) -------------
  logic [BTB_INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]       lk_tag;
  logic                      lk_hit;
  logic                      lk_pred;

  assign lk_idx  = PC_cur[BTB_INDEX_BITS-1:0];
  assign lk_tag  = PC_cur[WORD_SIZE-1:BTB_INDEX_BITS];
  assign lk_hit  = valid_arr[lk_idx] && (tag_arr[lk_idx] == lk_tag);
  assign lk_pred = lk_hit && ctr_arr[lk_idx][1];

  always_comb begin
    PC_next    = '0;
    PC_update  = 1'b0;
    pred_taken = 1'b0;
    if (reset_n) begin
      PC_update  = mispredict | ~stall;
      pred_taken = lk_pred;
      if (mispredict)   PC_next = correct_pc;
      else if (lk_pred) PC_next = tgt_arr[lk_idx];
      else              PC_next = PC_cur + WORD_SIZE'(1);
    end
  end

  // ---------------- Update path ----------------------------------------------
  logic [BTB_INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]       up_tag;
  logic                      up_hit;
  logic                      up_train;  // existing entry: step counter
  logic                      up_alloc;  // miss + taken: (re)allocate entry
  logic [1:0]                up_ctr_next;

  assign up_idx   = resolve_pc[BTB_INDEX_BITS-1:0];
  assign up_tag   = resolve_pc[WORD_SIZE-1:BTB_INDEX_BITS];
  assign up_hit   = valid_arr[up_idx] && (tag_arr[up_idx] == up_tag);
  assign up_train = resolve_valid && up_hit;
  assign up_alloc = resolve_valid && !up_hit && resolve_taken;

  sat_counter_2b u_sat_counter (
    .cur_ctr  (ctr_arr[up_idx]),
    .taken    (resolve_taken),
    .next_ctr (up_ctr_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic                 valid_reg;
      logic [TAG_BITS-1:0]  tag_reg;
      logic [WORD_SIZE-1:0] tgt_reg;
      logic [1:0]           ctr_reg;
      logic                 sel;

      assign sel = (up_idx == BTB_INDEX_BITS'(gi));

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
          tgt_reg   <= '0;
          ctr_reg   <= CTR_WNT;
        end else if (sel && up_train) begin
          ctr_reg <= up_ctr_next;
          if (resolve_taken) tgt_reg <= resolve_target;
        end else if (sel && up_alloc) begin
          valid_reg <= 1'b1;
          tag_reg   <= up_tag;
          tgt_reg   <= resolve_target;
          ctr_reg   <= CTR_WT;
        end
      end

      assign valid_arr[gi] = valid_reg;
      assign tag_arr[gi]   = tag_reg;
      assign tgt_arr[gi]   = tgt_reg;
      assign ctr_arr[gi]   = ctr_reg;
    end
  endgenerate

`ifdef BTB_STATS_EN
  logic [15:0] branches_reg;
  logic [15:0] mispredicts_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
    end else begin
      if (resolve_valid && branches_reg != 16'hFFFF)
        branches_reg <= branches_reg + 16'd1;
      if (mispredict && mispredicts_reg != 16'hFFFF)
        mispredicts_reg <= mispredicts_reg + 16'd1;
    end
  end

  assign stat_branches    = branches_reg;
  assign stat_mispredicts = mispredicts_reg;
`endif

endmodule

// File: tb/tb_next_pc_gen.sv
module tb_next_pc_gen;
  import next_pc_gen_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [WORD_SIZE-1:0] PC_cur;
  logic                 stall;
  logic                 resolve_valid;
  logic [WORD_SIZE-1:0] resolve_pc;
  logic                 resolve_taken;
  logic [WORD_SIZE-1:0] resolve_target;
  logic                 mispredict;
  logic [WORD_SIZE-1:0] correct_pc;
  logic [WORD_SIZE-1:0] PC_next;
  logic                 PC_update;
  logic                 pred_taken;
`ifdef BTB_STATS_EN
  logic [15:0]          stat_branches;
  logic [15:0]          stat_mispredicts;
`endif

  next_pc_gen #(.BTB_INDEX_BITS(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .PC_cur         (PC_cur),
    .stall          (stall),
    .resolve_valid  (resolve_valid),
    .resolve_pc     (resolve_pc),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .mispredict     (mispredict),
    .correct_pc     (correct_pc),
    .PC_next        (PC_next),
    .PC_update      (PC_update),
    .pred_taken     (pred_taken)
`ifdef BTB_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] nxt;
    logic        upd;
    logic        pt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Drive one cycle of stimulus at the falling edge, queue the expected
  // combinational outputs, then pop and compare before the next rising edge.
  task automatic step(input string tag, input logic rst_n, input logic [15:0] pc,
                      input logic stl, input logic rv, input logic [15:0] rpc,
                      input logic rt, input logic [15:0] rtgt, input logic mp,
                      input logic [15:0] cpc, input logic [15:0] e_next,
                      input logic e_upd, input logic e_pt);
    exp_t  e;
    string t;
    @(negedge clk);
    reset_n        = rst_n;
    PC_cur         = pc;
    stall          = stl;
    resolve_valid  = rv;
    resolve_pc     = rpc;
    resolve_taken  = rt;
    resolve_target = rtgt;
    mispredict     = mp;
    correct_pc     = cpc;
    exp_q.push_back('{nxt: e_next, upd: e_upd, pt: e_pt});
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".PC_next"}, PC_next, e.nxt);
    chk({t, ".PC_update"}, 16'(PC_update), 16'(e.upd));
    chk({t, ".pred_taken"}, 16'(pred_taken), 16'(e.pt));
    $display("step %-10s PC_cur=%h PC_next=%h PC_update=%b pred_taken=%b",
             t, pc, PC_next, PC_update, pred_taken);
  endtask

`ifdef BTB_STATS_EN
  task automatic check_stats(input string tag, input logic [15:0] eb, input logic [15:0] em);
    chk({tag, ".stat_branches"}, stat_branches, eb);
    chk({tag, ".stat_mispredicts"}, stat_mispredicts, em);
    $display("stats %-10s branches=%0d mispredicts=%0d", tag, stat_branches, stat_mispredicts);
  endtask
`endif

  initial begin
    reset_n = 1'b0; PC_cur = '0; stall = 1'b0; resolve_valid = 1'b0;
    resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;
    mispredict = 1'b0; correct_pc = '0;

    //    tag          rst  pc        stl rv  rpc       rt  rtgt      mp  cpc       next      upd pt
    step("rst0",       0, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    step("rst1",       0, 16'h1234, 0, 1, 16'h0012, 1, 16'h0040, 1, 16'h0123, 16'h0000, 0, 0);
    step("boot",       1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0001, 1, 0);
    step("wrap",       1, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
    step("cold12",     1, 16'h0012, 0, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 16'h0013, 1, 0);
    step("hit12",      1, 16'h0012, 0, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 16'h0040, 1, 1);
    step("wnt12",      1, 16'h0012, 0, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 16'h0013, 1, 0);
    step("snt12",      1, 16'h0012, 0, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 16'h0013, 1, 0);
    step("sat_lo",     1, 16'h0012, 0, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 16'h0013, 1, 0);
    step("wnt12b",     1, 16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0013, 1, 0);
    step("stall",      1, 16'h0020, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0021, 0, 0);
    step("stall_mp",   1, 16'h0020, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0123, 16'h0123, 1, 0);
    step("train_a",    1, 16'h0012, 0, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 16'h0013, 1, 0);
    step("train_b",    1, 16'h0012, 0, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 16'h0040, 1, 1);
    step("sat_hi",     1, 16'h0012, 0, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 16'h0040, 1, 1);
    step("dec_hi",     1, 16'h0012, 0, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 16'h0040, 1, 1);
    step("mp_hit",     1, 16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 16'h0200, 1, 1);
    step("alias",      1, 16'h0012, 0, 1, 16'h0112, 1, 16'h0080, 0, 16'h0000, 16'h0040, 1, 1);
    step("alias_old",  1, 16'h0012, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0013, 1, 0);
    step("alias_new",  1, 16'h0112, 0, 1, 16'h0112, 1, 16'h0090, 0, 16'h0000, 16'h0080, 1, 1);
    step("same_cyc",   1, 16'h0112, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0090, 1, 1);
    step("miss_nt",    1, 16'h0020, 0, 1, 16'h0035, 0, 16'h0000, 0, 16'h0000, 16'h0021, 1, 0);
    step("nt_nowr",    1, 16'h0035, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0036, 1, 0);
    step("rst_mid",    0, 16'h0112, 1, 1, 16'h0045, 1, 16'h0077, 1, 16'h0321, 16'h0000, 0, 0);
    step("cold_a",     1, 16'h0112, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0113, 1, 0);
`ifdef BTB_STATS_EN
    check_stats("after_rst", 16'd0, 16'd0);
`endif
    step("s1",         1, 16'h0045, 0, 1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 16'h0046, 1, 0);
    step("s2",         1, 16'h0100, 0, 1, 16'h0030, 0, 16'h0000, 1, 16'h0300, 16'h0300, 1, 0);
    step("s3",         1, 16'h0100, 0, 1, 16'h0031, 0, 16'h0000, 0, 16'h0000, 16'h0101, 1, 0);
    step("s4",         1, 16'h0100, 0, 1, 16'h0032, 0, 16'h0000, 1, 16'h0400, 16'h0400, 1, 0);
    step("s5",         1, 16'h0100, 0, 1, 16'h0033, 0, 16'h0000, 0, 16'h0000, 16'h0101, 1, 0);
    step("s_end",      1, 16'h0100, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0101, 1, 0);
`ifdef BTB_STATS_EN
    check_stats("five_two", 16'd5, 16'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/next_pc_gen.md
Name: next_pc_gen

Overview:
Drives the PC register's PC_next / PC_update inputs: the producing end of the PC update interface. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters and selects among sequential, predicted-taken and EX-stage correction targets. It honours IF stalls. It sits in the IF stage between the hazard unit, the EX branch-resolution logic and the PC register.

Parameters:
BTB_INDEX_BITS, 4, log2 of BTB entry count (16 entries); tag width = WORD_SIZE - BTB_INDEX_BITS

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous reset, active-low
PC_cur  input  WORD_SIZE  current PC from the PC register
stall  input  1  IF stall from hazard unit; hold PC
resolve_valid  input  1  EX stage has resolved a control instruction this cycle
resolve_pc  input  WORD_SIZE  PC of the resolved instruction
resolve_taken  input  1  actual direction
resolve_target  input  WORD_SIZE  actual taken target
mispredict  input  1  EX detected a wrong prediction; redirect
correct_pc  input  WORD_SIZE  redirect address
PC_next  output  WORD_SIZE  next PC to the PC register
PC_update  output  1  PC register load enable
pred_taken  output  1  prediction made for PC_cur, piped down with the instruction

Behaviour:
- Interface fixed: one clock, clk; reset_n synchronous, active-low.
- Lookup is combinational on PC_cur: idx = PC_cur[BTB_INDEX_BITS-1:0], tag = upper bits. hit = valid[idx] & (tag_arr[idx] == tag).
- pred_taken = hit & ctr[idx][1].
- PC_next priority:
  (1) mispredict: correct_pc.
  (2) pred_taken: tgt[idx].
  (3) otherwise: PC_cur + 1, modulo 2^WORD_SIZE (FFFF wraps to 0000).
- PC_update = mispredict | ~stall. Mispredict overrides stall.
- While reset_n is low: PC_update = 0, pred_taken = 0, PC_next = 0.
- BTB update at posedge clk when resolve_valid & reset_n:
  - Entry hit (valid, tag match on resolve_pc): ctr saturating +1 if taken, -1 if not taken. Clamps at 11 and 00. tgt <= resolve_target if taken.
  - Miss and taken: allocate/overwrite. valid = 1, tag, tgt <= resolve_target, ctr <= 10 (weakly taken).
  - Miss and not taken: no write.
- Same-cycle lookup and update of one index: lookup uses the pre-edge contents; no write-through bypass.
- Reset at posedge with reset_n low: all valid = 0, all ctr = 01, tgt/tag = 0. Any in-flight resolve that cycle is dropped. Reset mid-stall or mid-mispredict has the same effect.
- The block holds no PC state itself; its only sequential state is the BTB.

Optional Feature:
BTB_STATS_EN: when defined, adds outputs stat_branches [15:0] and stat_mispredicts [15:0].
- stat_branches counts resolve_valid cycles; stat_mispredicts counts mispredict cycles.
- Both are 16-bit saturating (stick at FFFF) and reset to 0.
When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared macro file (macro.v): WORD_SIZE (existing), plus counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
- One sub-module: sat_counter_2b, combinational (cur, taken) -> next, with saturation. Instantiated once on the update path.

Test Plan:
- Reset: hold reset_n=0 two cycles -> PC_update=0, pred_taken=0; first cycle after release with PC_cur=0000, stall=0 -> PC_next=0001, PC_update=1.
- Sequential wrap: PC_cur=FFFF, cold BTB -> PC_next=0000, pred_taken=0.
- Train: resolve_valid, resolve_pc=0012, taken, target=0040; next cycle PC_cur=0012 -> pred_taken=1, PC_next=0040. Then two not-taken resolves at 0012 -> ctr 00, PC_next=0013.
- Priority: stall=1 -> PC_update=0; stall=1 with mispredict=1, correct_pc=0123 -> PC_update=1, PC_next=0123. mispredict with a BTB hit -> correct_pc wins.
- Aliasing/collision: train 0012 taken->0040, then resolve 0112 taken->0080 (same idx, new tag) -> PC_cur=0012 misses (PC_next=0013), PC_cur=0112 -> 0080. Resolve at idx of PC_cur in the same cycle -> old prediction that cycle, new one next cycle.
- Stats (BTB_STATS_EN): 5 resolves, 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Reset mid-run -> both 0 and BTB cold.
